// File: rtl/fifo_level.sv
// Parametrised single-clock FIFO on a circular buffer with fill level, programmable
// almost-full/almost-empty thresholds, flush and sticky overflow/underflow flags.
module fifo_level #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_in,
  output logic [WIDTH-1:0] rdata,
  input  logic             shift_out,
  input  logic             flush,
  input  logic             clr_err,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_q;
  logic             push_acc;
  logic             pop_acc;
  logic             ovf_set;
  logic             udf_set;

  // Flags decode the registered level only, so no input reaches them combinationally.
  always_comb begin
    full         = (level_q == LW'(DEPTH));
    empty        = (level_q == '0);
    almost_full  = (32'(level_q) >= AF_LEVEL);
    almost_empty = (32'(level_q) <= AE_LEVEL);
    level        = level_q;
    rdata        = empty ? '1 : mem[rd_ptr];
  end

  always_comb begin
    push_acc   = shift_in & (~full | shift_out);
    pop_acc    = shift_out & ~empty;
    ovf_set    = shift_in & full & ~shift_out;
    udf_set    = shift_out & empty;
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr_nxt;
      if (pop_acc)  rd_ptr <= rd_ptr_nxt;
      level_q <= level_q + LW'(push_acc) - LW'(pop_acc);
      // A new error event beats a simultaneous clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res_n && !flush && push_acc) mem[wr_ptr] <= wdata;
  end

`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (res_n && !flush) begin
      if (shift_in && !push_acc)
        $display("%m: push rejected, wdata=%h level=%0d", wdata, level_q);
      if (shift_out && !pop_acc)
        $display("%m: pop rejected, rdata=%h level=%0d", rdata, level_q);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed vector table plus hand-written corner sequences and a queue-model soak
// for fifo_level at DEPTH=8 and DEPTH=5.
module tb_fifo_level;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] wdata;
  logic        shift_in, shift_out, flush, clr_err;

  logic [31:0] rdata8, rdata5;
  logic        full8, empty8, af8, ae8, ovf8, udf8;
  logic        full5, empty5, af5, ae5, ovf5, udf5;
  logic [3:0]  level8;
  logic [2:0]  level5;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fifo_level #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut (
    .clk(clk), .res_n(res_n), .wdata(wdata), .shift_in(shift_in), .rdata(rdata8),
    .shift_out(shift_out), .flush(flush), .clr_err(clr_err), .full(full8),
    .empty(empty8), .almost_full(af8), .almost_empty(ae8), .level(level8),
    .overflow(ovf8), .underflow(udf8)
  );

  fifo_level #(.WIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .res_n(res_n), .wdata(wdata), .shift_in(shift_in), .rdata(rdata5),
    .shift_out(shift_out), .flush(flush), .clr_err(clr_err), .full(full5),
    .empty(empty5), .almost_full(af5), .almost_empty(ae5), .level(level5),
    .overflow(ovf5), .underflow(udf5)
  );

  typedef struct {
    logic        si, so, fl, ce;
    logic [31:0] wd;
    int unsigned lvl;
    logic [31:0] rd;
    logic        f, e, af, ae, ov, un;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic si, logic so, logic fl, logic ce, logic [31:0] wd,
                              int unsigned lvl, logic [31:0] rd,
                              logic f, logic e, logic af, logic ae, logic ov, logic un);
    vec_t v;
    v.si = si; v.so = so; v.fl = fl; v.ce = ce; v.wd = wd;
    v.lvl = lvl; v.rd = rd; v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input int unsigned lvl, input logic [31:0] rd,
                      input logic f, input logic e, input logic af, input logic ae,
                      input logic ov, input logic un);
    chk({tag, " level"}, 32'(level8), lvl);
    chk({tag, " rdata"}, rdata8, rd);
    chk({tag, " full"}, 32'(full8), 32'(f));
    chk({tag, " empty"}, 32'(empty8), 32'(e));
    chk({tag, " almost_full"}, 32'(af8), 32'(af));
    chk({tag, " almost_empty"}, 32'(ae8), 32'(ae));
    chk({tag, " overflow"}, 32'(ovf8), 32'(ov));
    chk({tag, " underflow"}, 32'(udf8), 32'(un));
  endtask

  task automatic cyc(input logic si, input logic so, input logic fl, input logic ce,
                     input logic [31:0] wd);
    shift_in = si; shift_out = so; flush = fl; clr_err = ce; wdata = wd;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    logic [31:0] mq[$];
    logic        m_ov, m_un;
    int unsigned pushed, popped, k;

    res_n = 1'b0; shift_in = 1'b1; shift_out = 1'b0; flush = 1'b0; clr_err = 1'b0;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #1;
    chk8("reset", 0, ONES, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset level5", 32'(level5), 0);
    chk("reset empty5", 32'(empty5), 1);
    res_n = 1'b1;

    // fill, full corner cases, drain, empty corner cases, flush and clr_err
    vt.push_back(mk(1,0,0,0,32'h10, 1,32'h10, 0,0,0,1,0,0));
    vt.push_back(mk(1,0,0,0,32'h11, 2,32'h10, 0,0,0,1,0,0));
    vt.push_back(mk(1,0,0,0,32'h12, 3,32'h10, 0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,32'h13, 4,32'h10, 0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,32'h14, 5,32'h10, 0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,32'h15, 6,32'h10, 0,0,1,0,0,0));
    vt.push_back(mk(1,0,0,0,32'h16, 7,32'h10, 0,0,1,0,0,0));
    vt.push_back(mk(1,0,0,0,32'h17, 8,32'h10, 1,0,1,0,0,0));
    vt.push_back(mk(1,1,0,0,32'h18, 8,32'h11, 1,0,1,0,0,0));
    vt.push_back(mk(1,0,0,0,32'hAA, 8,32'h11, 1,0,1,0,1,0));
    vt.push_back(mk(0,0,0,1,32'h0,  8,32'h11, 1,0,1,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  7,32'h12, 0,0,1,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  6,32'h13, 0,0,1,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  5,32'h14, 0,0,0,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  4,32'h15, 0,0,0,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  3,32'h16, 0,0,0,0,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  2,32'h17, 0,0,0,1,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  1,32'h18, 0,0,0,1,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  0,ONES,   0,1,0,1,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  0,ONES,   0,1,0,1,0,1));
    vt.push_back(mk(1,1,0,0,32'h55, 1,32'h55, 0,0,0,1,0,1));
    vt.push_back(mk(1,0,0,0,32'h56, 2,32'h55, 0,0,0,1,0,1));
    vt.push_back(mk(1,0,0,0,32'h57, 3,32'h55, 0,0,0,0,0,1));
    vt.push_back(mk(1,0,0,0,32'h58, 4,32'h55, 0,0,0,0,0,1));
    vt.push_back(mk(1,0,0,0,32'h59, 5,32'h55, 0,0,0,0,0,1));
    vt.push_back(mk(1,0,1,0,32'h99, 0,ONES,   0,1,0,1,0,1));
    vt.push_back(mk(0,1,0,1,32'h0,  0,ONES,   0,1,0,1,0,1));
    vt.push_back(mk(0,0,0,1,32'h0,  0,ONES,   0,1,0,1,0,0));
    vt.push_back(mk(1,0,0,0,32'h77, 1,32'h77, 0,0,0,1,0,0));
    vt.push_back(mk(0,1,0,0,32'h0,  0,ONES,   0,1,0,1,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].si, vt[i].so, vt[i].fl, vt[i].ce, vt[i].wd);
      chk8($sformatf("vec%0d", i), vt[i].lvl, vt[i].rd, vt[i].f, vt[i].e,
           vt[i].af, vt[i].ae, vt[i].ov, vt[i].un);
    end

    // reset mid-operation discards data and ignores the pop in that cycle
    cyc(1,0,0,0,32'hA1); cyc(1,0,0,0,32'hA2); cyc(1,0,0,0,32'hA3);
    res_n = 1'b0;
    cyc(1,1,1,0,32'hA4);
    res_n = 1'b1;
    chk8("midreset", 0, ONES, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // DEPTH=5 wrap: batches of 3 pushes then 3 pops over 20 words
    pushed = 0; popped = 0;
    while (pushed < 20) begin
      k = (20 - pushed < 3) ? 20 - pushed : 3;
      for (int j = 0; j < k; j++) begin
        cyc(1,0,0,0,32'h100 + pushed);
        pushed++;
        chk("wrap level5 push", 32'(level5), pushed - popped);
      end
      for (int j = 0; j < k; j++) begin
        chk("wrap rdata5", rdata5, 32'h100 + popped);
        cyc(0,1,0,0,32'h0);
        popped++;
        chk("wrap level5 pop", 32'(level5), pushed - popped);
      end
    end
    chk("wrap empty5", 32'(empty5), 1);
    for (int j = 0; j < 5; j++) cyc(1,0,0,0,32'h200 + j);
    chk("d5 full", 32'(full5), 1);
    chk("d5 almost_full", 32'(af5), 1);
    chk("d5 head", rdata5, 32'h200);
    cyc(1,0,0,0,32'h2FF);
    chk("d5 overflow", 32'(ovf5), 1);
    chk("d5 level", 32'(level5), 5);

    // randomised soak of the DEPTH=8 instance against a queue model
    res_n = 1'b0; cyc(0,0,0,0,32'h0); res_n = 1'b1;
    mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic si, so, fl, ce, fm, em, set_o, set_u;
      logic [31:0] wd;
      si = ($urandom_range(99) < 55);
      so = ($urandom_range(99) < 45);
      fl = ($urandom_range(199) == 0);
      ce = ($urandom_range(19) == 0);
      wd = $urandom;
      if (!fl) begin
        fm = (mq.size() == 8);
        em = (mq.size() == 0);
        set_o = si & fm & ~so;
        set_u = so & em;
        if (so && !em) void'(mq.pop_front());
        if (si && (!fm || so)) mq.push_back(wd);
        if (set_o) m_ov = 1'b1; else if (ce) m_ov = 1'b0;
        if (set_u) m_un = 1'b1; else if (ce) m_un = 1'b0;
      end else begin
        mq.delete();
      end
      cyc(si, so, fl, ce, wd);
      chk8($sformatf("rnd%0d", c), mq.size(), (mq.size() != 0) ? mq[0] : ONES,
           mq.size() == 8, mq.size() == 0, mq.size() >= 6, mq.size() <= 2, m_ov, m_un);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
